// File: rtl/load_use_scoreboard_if.sv
// -----------------------------------------------------------------------------
// load_use_scoreboard_if
//   Groups the ID-stage request, writeback and flush signals seen by the
//   load-use scoreboard together with its stall/issue responses.
//
//   master : pipeline side (drives ID/WB/flush, receives stall/issue)
//   slave  : scoreboard side
//
//   id_valid    valid instruction in ID
//   id_rs1/2    ID source registers, qualified by id_use_rs1/2
//   id_rd       ID destination, id_regwr says it is written
//   id_is_load  ID instruction is a load
//   kill_idex   instruction issued last cycle (now in ID/EX) is cancelled
//   wb_valid    load writeback completes this cycle, to wb_rd
//   stall       hold PC and IF/ID, bubble ID/EX
//   issue       ID->EX transfer this cycle
// -----------------------------------------------------------------------------
interface load_use_scoreboard_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic       id_use_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_regwr;
  logic       id_is_load;
  logic       kill_idex;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       stall;
  logic       issue;

  modport master (
    output id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2, id_rd,
           id_regwr, id_is_load, kill_idex, wb_valid, wb_rd,
    input  stall, issue
  );

  modport slave (
    input  id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2, id_rd,
           id_regwr, id_is_load, kill_idex, wb_valid, wb_rd,
    output stall, issue
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// -----------------------------------------------------------------------------
// load_use_scoreboard
//   Producer-side hazard tracking beside the ID stage. Remembers the
//   destination registers of in-flight variable-latency loads and stalls ID
//   while a source (RAW) or destination (WAW) hits one of them, or while the
//   pending table is full and another load wants to issue.
//
// Parameters
//   NREG          architectural registers (x0 never pending)
//   MAX_PEND      maximum outstanding loads
//   STALL_TIMEOUT consecutive stall cycles that raise err_timeout
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   sb           load_use_scoreboard_if.slave (ID / WB / flush / stall / issue)
//   pend_mask    registered pending bits, one per register
//   pend_cnt     registered outstanding-load count
//   err_timeout  sticky, stall held STALL_TIMEOUT cycles; cleared by rst_n only
//
// Optional feature (macro SB_PERF_CNT_EN)
//   stall_cycles +1 each stall cycle (wraps)
//   load_stalls  +1 per RUN->STALL entry caused by a source/dest hit
// -----------------------------------------------------------------------------
module load_use_scoreboard #(
  parameter int unsigned NREG          = 32,
  parameter int unsigned MAX_PEND      = 4,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  load_use_scoreboard_if.slave              sb,
  output logic [NREG-1:0]                   pend_mask,
  output logic [$clog2(MAX_PEND+1)-1:0]     pend_cnt,
  output logic                              err_timeout
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0]                       stall_cycles,
  output logic [31:0]                       load_stalls
`endif
);

  localparam int unsigned CW = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_PEND);
  localparam logic [7:0]    TIMEOUT  = 8'(STALL_TIMEOUT);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NREG-1:0] wb_vec;
  logic [NREG-1:0] busy_vec;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] wb_clr_vec;
  logic [NREG-1:0] kill_vec;
  logic [NREG-1:0] mask_nxt;
  logic [CW:0]     cnt_sum;

  logic            hazard;
  logic            cnt_full;
  logic            stall_int;
  logic            issue_int;
  logic            set_req;
  logic            wb_hit;
  logic            kill_hit;

  logic            last_vld;
  logic [4:0]      last_rd;

  logic            in_stall_state;
  logic [7:0]      stall_ctr;

  // ---------------------------------------------------------------------------
  // Hazard detection (combinational, same cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_vec = '0;
    if (sb.wb_valid) wb_vec = NREG'(1) << sb.wb_rd;
    // A writeback landing this cycle is forwarded, so its register is not busy.
    busy_vec    = pend_mask & ~wb_vec;
    busy_vec[0] = 1'b0;
  end

  always_comb begin
    hazard    = (sb.id_use_rs1 & busy_vec[sb.id_rs1])
              | (sb.id_use_rs2 & busy_vec[sb.id_rs2])
              | (sb.id_regwr   & busy_vec[sb.id_rd]);   // WAW keeps WB order
    cnt_full  = (pend_cnt == CNT_FULL);
    stall_int = sb.id_valid & (hazard | (sb.id_is_load & cnt_full & ~sb.wb_valid));
    issue_int = sb.id_valid & ~stall_int;
  end

  assign sb.stall = stall_int;
  assign sb.issue = issue_int;

  // ---------------------------------------------------------------------------
  // Pending table update
  // ---------------------------------------------------------------------------
  always_comb begin
    set_req  = issue_int & sb.id_is_load & (sb.id_rd != 5'd0);
    wb_hit   = sb.wb_valid & pend_mask[sb.wb_rd];
    // If the killed load's register is also written back this cycle, only
    // one of them may release the entry.
    kill_hit = sb.kill_idex & last_vld & pend_mask[last_rd]
             & ~(wb_hit & (sb.wb_rd == last_rd));

    set_vec    = '0;
    wb_clr_vec = '0;
    kill_vec   = '0;
    if (set_req)  set_vec    = NREG'(1) << sb.id_rd;
    if (wb_hit)   wb_clr_vec = NREG'(1) << sb.wb_rd;
    if (kill_hit) kill_vec   = NREG'(1) << last_rd;

    mask_nxt = (pend_mask & ~wb_clr_vec & ~kill_vec) | set_vec;
    cnt_sum  = {1'b0, pend_cnt} + (CW+1)'(set_req)
             - (CW+1)'(wb_hit) - (CW+1)'(kill_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mask <= '0;
      pend_cnt  <= '0;
    end else begin
      pend_mask <= mask_nxt;
      pend_cnt  <= cnt_sum[CW-1:0];
    end
  end

  // Last-issue register: identifies what kill_idex cancels next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld <= 1'b0;
      last_rd  <= '0;
    end else begin
      last_vld <= set_req;
      last_rd  <= sb.id_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (stall_int)  state_nxt = STALL;
      STALL:   if (!stall_int) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    in_stall_state = (state == STALL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_ctr <= '0;
    end else if (!in_stall_state) begin
      stall_ctr <= '0;
    end else if (stall_ctr != '1) begin
      stall_ctr <= stall_ctr + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (stall_ctr == TIMEOUT) begin
      err_timeout <= 1'b1;
    end
  end

`ifdef SB_PERF_CNT_EN
  logic hit_entry;

  always_comb begin
    hit_entry = (state == RUN) & stall_int & sb.id_valid & hazard;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      load_stalls  <= '0;
    end else begin
      if (stall_int) stall_cycles <= stall_cycles + 32'd1;
      if (hit_entry) load_stalls  <= load_stalls + 32'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_cnt_no_wrap : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_sum <= (CW+1)'(MAX_PEND));

  a_x0_never_pending : assert property (@(posedge clk) disable iff (!rst_n)
    !pend_mask[0]);

endmodule
